// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: drives enables and NOP selects for the five pipeline register banks
// from load-use, taken-branch and data-memory-wait events, with a memory watchdog.
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_use_haz,
    input  logic             br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_LIM = WC_W'(MAX_WAIT);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]      state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            timeout_set;
    logic            freeze;

    assign freeze = dmem_req & ~dmem_ready;

    // Freeze outranks the branch: the branch sits frozen in EX and flushes once the freeze ends.
    always_comb begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_en     = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (!reset && state != S_ERR) begin
            if (freeze) begin
                memwb_en     = 1'b1;
                memwb_bubble = 1'b1;
            end else if (br_taken) begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (ld_use_haz) begin
                {idex_en, exmem_en, memwb_en} = 3'b111;
                idex_flush = 1'b1;
            end else begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_set  = 1'b0;
        case (state)
            S_RUN: begin
                if (freeze) begin
                    state_nxt    = S_WAIT;
                    wait_cnt_nxt = WC_W'(1);
                end
            end
            S_WAIT: begin
                if (!freeze) begin
                    state_nxt    = S_RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_LIM) begin
                    state_nxt   = S_ERR;
                    timeout_set = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            S_ERR: state_nxt = S_ERR;
            default: begin
                state_nxt    = S_RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout_set)
                mem_timeout <= 1'b1;
            // ERR also holds pc_en low but is not a stall worth counting.
            if (!pc_en && state != S_ERR && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end
endmodule
